// File: rtl/train_balancer_pkg.sv
// Shared types and default sizing for the train balancer stations (pickup and dropoff).
package train_balancer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_DEPART  = 2'd2
    } station_state_e;

    localparam int DEF_QUEUE_LENGTH        = 3;
    localparam int DEF_MAX_STOREABLE       = 128000;
    localparam int DEF_UNITS_IN_TRAIN_LOAD = 8000;
    localparam int DEF_LOAD_RATE           = 400;
    localparam int DEF_WAIT_CYCLES         = 16;
    localparam int DEF_INT                 = 31;

endpackage

// File: rtl/get_load_transfer.sv
// Per-cycle transfer amount: min(LOAD_RATE, stored units, room left in the train), zero when not loading.
module get_load_transfer #(
    parameter int LOAD_RATE           = 400,
    parameter int UNITS_IN_TRAIN_LOAD = 8000,
    parameter int INT                 = 31
) (
    input  logic           loading,
    input  logic [INT:0]   units_stored,
    input  logic [INT:0]   contents,
    output logic [INT:0]   transfer
);

    localparam logic [INT:0] RATE_W = (INT+1)'(LOAD_RATE);
    localparam logic [INT:0] FULL_W = (INT+1)'(UNITS_IN_TRAIN_LOAD);

    logic [INT:0] room;
    logic [INT:0] pick;

    always_comb begin
        room     = (contents >= FULL_W) ? '0 : FULL_W - contents;
        pick     = RATE_W;
        transfer = '0;
        if (units_stored < pick) pick = units_stored;
        if (room < pick)         pick = room;
        if (loading)             transfer = pick;
    end

endmodule

// File: rtl/pickup_train_station.sv
// Pickup station: accumulates produced units and loads one stopped train at a time.
// Define PICKUP_PARTIAL_DEPART_EN to let a stalled, partially loaded train leave after WAIT_CYCLES.
module pickup_train_station
    import train_balancer_pkg::*;
#(
    parameter int QUEUE_LENGTH        = DEF_QUEUE_LENGTH,
    parameter int MAX_STOREABLE       = DEF_MAX_STOREABLE,
    parameter int UNITS_IN_TRAIN_LOAD = DEF_UNITS_IN_TRAIN_LOAD,
    parameter int LOAD_RATE           = DEF_LOAD_RATE,
    parameter int WAIT_CYCLES         = DEF_WAIT_CYCLES,
    parameter int INT                 = DEF_INT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [INT:0]   precision,
    input  logic [INT:0]   units_produced,
    input  logic           train_arrive,
    input  logic [INT:0]   train_id,
    output logic [INT:0]   units_at_this_station,
    output logic [INT:0]   stopped_train_id,
    output logic [INT:0]   stopped_train_contents,
    output logic           train_depart,
    output logic           train_rejected,
    output logic [INT:0]   trains_limit,
    output logic [INT:0]   percentage_available,
    output station_state_e dbg_state
);

    localparam int W = INT + 1;
    localparam logic [W:0]     MAX_W  = (W+1)'(MAX_STOREABLE);
    localparam logic [W-1:0]   FULL_W = W'(UNITS_IN_TRAIN_LOAD);
    localparam logic [W:0]     FULL_X = (W+1)'(UNITS_IN_TRAIN_LOAD);
    localparam logic [W:0]     QL_X   = (W+1)'(QUEUE_LENGTH);
    localparam logic [2*W-1:0] MAX_P  = (2*W)'(MAX_STOREABLE);

    station_state_e state_q, state_d;
    logic [W-1:0] u_q, u_d;
    logic [W-1:0] t_q, t_d;
    logic [W-1:0] contents_q, contents_d;
    logic         depart_q, depart_d;
    logic         rejected_q, rejected_d;
    logic [W-1:0] limit_q, limit_d;
    logic [W-1:0] pct_q, pct_d;
`ifdef PICKUP_PARTIAL_DEPART_EN
    localparam logic [W-1:0] WAIT_W = W'(WAIT_CYCLES);
    logic [W-1:0] stall_q, stall_d;
`endif

    logic [W-1:0]   x;
    logic [W:0]     u_sum;
    logic [W:0]     total;
    logic [W:0]     quot;
    logic [2*W-1:0] prod;

    get_load_transfer #(
        .LOAD_RATE          (LOAD_RATE),
        .UNITS_IN_TRAIN_LOAD(UNITS_IN_TRAIN_LOAD),
        .INT                (INT)
    ) u_xfer (
        .loading     (state_q == ST_LOADING),
        .units_stored(u_q),
        .contents    (contents_q),
        .transfer    (x)
    );

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        contents_d = contents_q;
`ifdef PICKUP_PARTIAL_DEPART_EN
        stall_d    = stall_q;
`endif
        // x never exceeds u_q, so the extra bit only has to absorb production overflow.
        u_sum = {1'b0, u_q} + {1'b0, units_produced} - {1'b0, x};
        u_d   = (u_sum > MAX_W) ? MAX_W[W-1:0] : u_sum[W-1:0];

        rejected_d = train_arrive && ((state_q != ST_IDLE) || (train_id == '0));

        case (state_q)
            ST_IDLE: begin
                if (train_arrive && (train_id != '0)) begin
                    state_d    = ST_LOADING;
                    t_d        = train_id;
                    contents_d = '0;
`ifdef PICKUP_PARTIAL_DEPART_EN
                    stall_d    = '0;
`endif
                end
            end
            ST_LOADING: begin
                contents_d = contents_q + x;
                if (contents_q == FULL_W) state_d = ST_DEPART;
`ifdef PICKUP_PARTIAL_DEPART_EN
                if (x != '0)                stall_d = '0;
                else if (stall_q != WAIT_W) stall_d = stall_q + 1'b1;
                if ((stall_q == WAIT_W) && (contents_q != '0)) state_d = ST_DEPART;
`endif
            end
            ST_DEPART: begin
                state_d    = ST_IDLE;
                t_d        = '0;
                contents_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        depart_d = (state_d == ST_DEPART);

        total   = {1'b0, u_q} + {1'b0, contents_q};
        quot    = total / FULL_X;
        limit_d = (quot > QL_X) ? QL_X[W-1:0] : quot[W-1:0];

        prod  = {{W{1'b0}}, u_q} * {{W{1'b0}}, precision};
        pct_d = W'(prod / MAX_P);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            u_q        <= '0;
            t_q        <= '0;
            contents_q <= '0;
            depart_q   <= 1'b0;
            rejected_q <= 1'b0;
            limit_q    <= '0;
            pct_q      <= '0;
`ifdef PICKUP_PARTIAL_DEPART_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            u_q        <= u_d;
            t_q        <= t_d;
            contents_q <= contents_d;
            depart_q   <= depart_d;
            rejected_q <= rejected_d;
            limit_q    <= limit_d;
            pct_q      <= pct_d;
`ifdef PICKUP_PARTIAL_DEPART_EN
            stall_q    <= stall_d;
`endif
        end
    end

    assign units_at_this_station  = u_q;
    assign stopped_train_id       = t_q;
    assign stopped_train_contents = contents_q;
    assign train_depart           = depart_q;
    assign train_rejected         = rejected_q;
    assign trains_limit           = limit_q;
    assign percentage_available   = pct_q;
    assign dbg_state              = state_q;

endmodule

// File: tb/tb_pickup_train_station.sv
// Directed bench for pickup_train_station with default parameters; inputs change on the falling edge.
module tb_pickup_train_station;
    import train_balancer_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    precision;
    logic [31:0]    units_produced;
    logic           train_arrive;
    logic [31:0]    train_id;
    logic [31:0]    units_at_this_station;
    logic [31:0]    stopped_train_id;
    logic [31:0]    stopped_train_contents;
    logic           train_depart;
    logic           train_rejected;
    logic [31:0]    trains_limit;
    logic [31:0]    percentage_available;
    station_state_e dbg_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pickup_train_station dut (
        .clk                   (clk),
        .rst                   (rst),
        .precision             (precision),
        .units_produced        (units_produced),
        .train_arrive          (train_arrive),
        .train_id              (train_id),
        .units_at_this_station (units_at_this_station),
        .stopped_train_id      (stopped_train_id),
        .stopped_train_contents(stopped_train_contents),
        .train_depart          (train_depart),
        .train_rejected        (train_rejected),
        .trains_limit          (trains_limit),
        .percentage_available  (percentage_available),
        .dbg_state             (dbg_state)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_u"}, units_at_this_station, 0);
        chk({tag, "_t"}, stopped_train_id, 0);
        chk({tag, "_contents"}, stopped_train_contents, 0);
        chk({tag, "_depart"}, 32'(train_depart), 0);
        chk({tag, "_rejected"}, 32'(train_rejected), 0);
        chk({tag, "_limit"}, trains_limit, 0);
        chk({tag, "_pct"}, percentage_available, 0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        rst = 1'b1; precision = 32'd1000; units_produced = '0;
        train_arrive = 1'b0; train_id = '0;
        @(negedge clk);
        tick(2);
        chk_all_zero("reset");

        // Fill storage to capacity, then stop producing.
        rst = 1'b0; units_produced = 32'd128000;
        tick(1);
        chk("fill_u", units_at_this_station, 128000);
        units_produced = '0;
        tick(1);
        chk("fill_pct", percentage_available, 1000);
        chk("fill_limit", trains_limit, 3);

        // Full load of train 5.
        train_arrive = 1'b1; train_id = 32'd5;
        tick(1);
        train_arrive = 1'b0;
        chk("arr5_state", 32'(dbg_state), 32'(ST_LOADING));
        chk("arr5_t", stopped_train_id, 5);
        chk("arr5_contents", stopped_train_contents, 0);
        tick(1);
        chk("load1_contents", stopped_train_contents, 400);
        chk("load1_u", units_at_this_station, 127600);
        train_arrive = 1'b1; train_id = 32'd9;
        tick(1);
        train_arrive = 1'b0;
        chk("rej9_pulse", 32'(train_rejected), 1);
        chk("rej9_t", stopped_train_id, 5);
        chk("load2_contents", stopped_train_contents, 800);
        tick(1);
        chk("rej9_clear", 32'(train_rejected), 0);
        chk("load3_contents", stopped_train_contents, 1200);
        tick(17);
        chk("full_contents", stopped_train_contents, 8000);
        chk("full_u", units_at_this_station, 120000);
        chk("full_no_depart", 32'(train_depart), 0);
        tick(1);
        chk("depart_pulse", 32'(train_depart), 1);
        chk("depart_t", stopped_train_id, 5);
        chk("depart_contents", stopped_train_contents, 8000);
        chk("depart_state", 32'(dbg_state), 32'(ST_DEPART));
        tick(1);
        chk("after_depart", 32'(train_depart), 0);
        chk("after_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("after_t", stopped_train_id, 0);
        chk("after_contents", stopped_train_contents, 0);
        chk("after_u", units_at_this_station, 120000);

        // Invalid id while idle.
        train_arrive = 1'b1; train_id = 32'd0;
        tick(1);
        train_arrive = 1'b0;
        chk("rej0_pulse", 32'(train_rejected), 1);
        chk("rej0_state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset in the middle of loading.
        train_arrive = 1'b1; train_id = 32'd5;
        tick(1);
        train_arrive = 1'b0;
        tick(6);
        chk("mid_contents", stopped_train_contents, 2400);
        rst = 1'b1;
        tick(1);
        chk_all_zero("midrst");
        rst = 1'b0;

        // Starved train 7: 1000 units available.
        units_produced = 32'd1000;
        tick(1);
        units_produced = '0;
        chk("starve_u0", units_at_this_station, 1000);
        train_arrive = 1'b1; train_id = 32'd7;
        tick(1);
        train_arrive = 1'b0;
        tick(3);
        chk("starve_contents", stopped_train_contents, 1000);
        chk("starve_u", units_at_this_station, 0);
`ifdef PICKUP_PARTIAL_DEPART_EN
        tick(16);
        chk("partial_wait", 32'(train_depart), 0);
        tick(1);
        chk("partial_depart", 32'(train_depart), 1);
        chk("partial_contents", stopped_train_contents, 1000);
        chk("partial_t", stopped_train_id, 7);
        tick(1);
        chk("partial_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("partial_t0", stopped_train_id, 0);
`else
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("starve_no_depart", 32'(train_depart), 0);
        end
        chk("starve_state", 32'(dbg_state), 32'(ST_LOADING));
        chk("starve_limit", trains_limit, 0);
        chk("starve_hold", stopped_train_contents, 1000);
`endif

        // Saturation and scaled percentage.
        rst = 1'b1;
        tick(1);
        rst = 1'b0; units_produced = 32'd127900;
        tick(1);
        chk("sat_u0", units_at_this_station, 127900);
        units_produced = 32'd500;
        tick(1);
        chk("sat_u", units_at_this_station, 128000);
        chk("sat_pct_trunc", percentage_available, 999);
        chk("sat_limit0", trains_limit, 3);
        units_produced = '0;
        tick(1);
        chk("sat_pct", percentage_available, 1000);
        chk("sat_limit", trains_limit, 3);
        precision = 32'd0;
        tick(1);
        chk("prec0_pct", percentage_available, 0);
        precision = 32'd100;
        tick(1);
        chk("prec100_pct", percentage_available, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
